// File: rtl/mem_out_ctrl_if.sv
// rtl/mem_out_ctrl_if.sv - result-row write stream, readout stream and output SRAM bank bus
interface mem_out_ctrl_if #(
    parameter int SRAM_COUNT = 16,
    parameter int SRAM_ADDR  = 4,
    parameter int WORD_LEN   = 32
);
    logic                            wr_valid;
    logic                            wr_ready;
    logic                            wr_last;
    logic [SRAM_COUNT*WORD_LEN-1:0]  wr_data;
    logic                            rd_valid;
    logic                            rd_ready;
    logic                            rd_last;
    logic [SRAM_COUNT*WORD_LEN-1:0]  rd_data;
    logic [SRAM_COUNT-1:0]           CEN;
    logic [SRAM_COUNT-1:0]           WEN;
    logic [SRAM_COUNT*SRAM_ADDR-1:0] A;
    logic [SRAM_COUNT*WORD_LEN-1:0]  D;
    logic [SRAM_COUNT*WORD_LEN-1:0]  Q;

    modport master (
        input  wr_valid, wr_last, wr_data, rd_ready, Q,
        output wr_ready, rd_valid, rd_last, rd_data, CEN, WEN, A, D
    );

    modport slave (
        output wr_valid, wr_last, wr_data, rd_ready, Q,
        input  wr_ready, rd_valid, rd_last, rd_data, CEN, WEN, A, D
    );
endinterface

// File: rtl/mem_out_ctrl.sv
// rtl/mem_out_ctrl.sv - fills the output SRAM banks one result row at a time and drains them in order
module mem_out_ctrl #(
    parameter int SRAM_COUNT = 16,
    parameter int SRAM_ADDR  = 4,
    parameter int WORD_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fill_start,
    input  logic                 drain_start,
    output logic [SRAM_ADDR:0]   rows,
    output logic                 busy,
    output logic                 done,
    mem_out_ctrl_if.master       bus
);
    localparam int DW = SRAM_COUNT * WORD_LEN;
    localparam logic [SRAM_ADDR:0] DEPTH = {1'b1, {SRAM_ADDR{1'b0}}};
    localparam logic [SRAM_ADDR:0] ONE   = {{SRAM_ADDR{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t               state, state_next;
    logic [SRAM_ADDR:0]   ptr, rows_q, shown;
    logic                 rd_valid_q, done_q;
    logic [SRAM_ADDR-1:0] a_q;
    logic [DW-1:0]        d_q;

    logic wr_fire, rd_issue, rd_fire, last_shown, access;
    logic go_fill, go_drain, empty_drain, fill_end, drain_end;

    assign last_shown = rd_valid_q && (shown == rows_q - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        wr_fire     = 1'b0;
        rd_issue    = 1'b0;
        rd_fire     = 1'b0;
        go_fill     = 1'b0;
        go_drain    = 1'b0;
        empty_drain = 1'b0;
        fill_end    = 1'b0;
        drain_end   = 1'b0;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_next = FILL;
                    go_fill    = 1'b1;
                end else if (drain_start) begin
                    if (rows_q != '0) begin
                        state_next = DRAIN;
                        go_drain   = 1'b1;
                    end else begin
                        empty_drain = 1'b1;
                    end
                end
            end
            FILL: begin
                wr_fire = bus.wr_valid && (ptr < DEPTH);
                if (wr_fire && (bus.wr_last || (ptr + ONE == DEPTH))) begin
                    state_next = IDLE;
                    fill_end   = 1'b1;
                end
            end
            DRAIN: begin
                rd_fire  = rd_valid_q && bus.rd_ready;
                // A new read may be issued in the same cycle the shown row is taken.
                rd_issue = (ptr < rows_q) && (!rd_valid_q || bus.rd_ready);
                if (rd_fire && last_shown) begin
                    state_next = IDLE;
                    drain_end  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            rows_q     <= '0;
            shown      <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            a_q        <= '0;
            d_q        <= '0;
        end else begin
            done_q <= fill_end || drain_end || empty_drain;
            if (go_fill) begin
                ptr    <= '0;
                rows_q <= '0;
            end
            if (go_drain) ptr <= '0;
            if (wr_fire) begin
                ptr    <= ptr + ONE;
                rows_q <= (rows_q == DEPTH) ? rows_q : rows_q + ONE;
                a_q    <= ptr[SRAM_ADDR-1:0];
                d_q    <= bus.wr_data;
            end
            if (rd_issue) begin
                ptr        <= ptr + ONE;
                a_q        <= ptr[SRAM_ADDR-1:0];
                shown      <= ptr;
                rd_valid_q <= 1'b1;
            end else if (rd_fire) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    // Bank strobes are combinational so the access lands in the handshake cycle.
    assign access       = wr_fire || rd_issue;
    assign bus.CEN      = access  ? '0 : '1;
    assign bus.WEN      = wr_fire ? '0 : '1;
    assign bus.A        = {SRAM_COUNT{access ? ptr[SRAM_ADDR-1:0] : a_q}};
    assign bus.D        = wr_fire ? bus.wr_data : d_q;
    assign bus.wr_ready = (state == FILL) && (ptr < DEPTH);
    assign bus.rd_valid = rd_valid_q && (state == DRAIN);
    assign bus.rd_last  = last_shown && (state == DRAIN);
    assign bus.rd_data  = bus.Q;
    assign rows         = rows_q;
    assign busy         = (state != IDLE);
    assign done         = done_q;
endmodule

// File: doc/mem_out_ctrl.md
MEM_OUT_CTRL -- requirements
Module: mem_out_ctrl

Interface
REQ-001 Parameter SRAM_COUNT, default 16, SHALL set the number of output SRAM banks, one result lane per bank.
REQ-002 Parameter SRAM_ADDR, default 4, SHALL set the bank address width; DEPTH = 2^SRAM_ADDR rows.
REQ-003 Parameter WORD_LEN, default 32, SHALL set the bits per bank word.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 fill_start  in  1  SHALL be a one-cycle pulse that begins a new fill.
REQ-007 wr_valid, wr_last  in  1 each  SHALL carry the producer result-row handshake; wr_last marks the final row.
REQ-008 wr_data  in  SRAM_COUNT*WORD_LEN  SHALL carry the result row; lane i maps to bank i.
REQ-009 wr_ready  out  1  SHALL indicate that a row is accepted this cycle.
REQ-010 drain_start  in  1  SHALL be a one-cycle pulse that begins readout.
REQ-011 rd_valid, rd_last  out  1 each  SHALL carry the consumer handshake; rd_last marks the final row.
REQ-012 rd_ready  in  1  SHALL indicate that the consumer accepts the current row.
REQ-013 rd_data  out  SRAM_COUNT*WORD_LEN  SHALL be the row being read out.
REQ-014 rows  out  SRAM_ADDR+1  SHALL report the number of rows written in the last fill.
REQ-015 busy  out  1  SHALL be high while the state is not IDLE.
REQ-016 done  out  1  SHALL be a one-cycle pulse when a fill or drain completes.
REQ-017 CEN, WEN  out  SRAM_COUNT each  SHALL be the active-low bank chip-enable and write-enable vectors.
REQ-018 A  out  SRAM_COUNT*SRAM_ADDR  SHALL be the per-bank address, with all lanes carrying the same row address.
REQ-019 D  out  SRAM_COUNT*WORD_LEN  SHALL be the bank write data; Q  in  SRAM_COUNT*WORD_LEN  SHALL be the bank read data.

Function
REQ-020 The states SHALL be IDLE, FILL and DRAIN, with a registered row pointer ptr of width SRAM_ADDR+1.
REQ-021 IDLE + fill_start SHALL go to FILL and set ptr=0 and rows=0.
REQ-022 In IDLE, drain_start with rows>0 SHALL go to DRAIN with ptr=0.
REQ-023 In IDLE, drain_start with rows==0 SHALL pulse done and remain in IDLE.
REQ-024 fill_start and drain_start SHALL be ignored outside IDLE; if both are asserted in IDLE in the same cycle, fill_start SHALL win.
REQ-025 In FILL, wr_ready SHALL equal (ptr<DEPTH).
REQ-026 A FILL write SHALL occur when wr_valid&&wr_ready, within the same cycle: CEN=0 and WEN=0 on all banks, A=ptr[SRAM_ADDR-1:0], D=wr_data; then ptr++ and rows++.
REQ-027 An accepted row with wr_last=1, or the acceptance that makes ptr==DEPTH, SHALL return the block to IDLE with a done pulse on the next cycle.
REQ-028 wr_valid while ptr==DEPTH SHALL NOT be accepted.
REQ-029 In DRAIN, a read SHALL be issued when ptr<rows && (!rd_valid || rd_ready): CEN=0, WEN=1, A=ptr; then ptr++.
REQ-030 rd_valid SHALL rise the cycle after a read is issued and SHALL hold until rd_valid&&rd_ready.
REQ-031 rd_data SHALL equal Q; the banks hold Q while CEN=1, so the row SHALL remain stable while stalled.
REQ-032 A handshake and the next read issue SHALL occur in the same cycle, sustaining one row per cycle under rd_ready=1.
REQ-033 rd_last SHALL equal rd_valid && (the row shown is row rows-1).
REQ-034 The handshake on the rd_last row SHALL return the block to IDLE and pulse done.
REQ-035 When no access is issued, CEN and WEN SHALL be all ones; A and D are don't-care but SHALL hold their previous values.
REQ-036 wr_ready SHALL be 0 outside FILL, and rd_valid SHALL be 0 outside DRAIN.
REQ-037 The row count SHALL saturate at DEPTH, and ptr SHALL never wrap.

Reset
REQ-038 rst_n=0 SHALL asynchronously force: state=IDLE, ptr=0, rows=0, CEN=WEN=all ones, A=0, D=0, wr_ready=0, rd_valid=0, rd_last=0, done=0, busy=0.
REQ-039 On rst_n assertion mid-FILL or mid-DRAIN, the partial transfer SHALL be abandoned; bank contents are undefined to the controller.
REQ-040 After rst_n deasserts, the first legal command SHALL be accepted on the following rising edge.

Verification
REQ-041 Fill of 5 rows (lane i = row*16+i), wr_last on row 4 -> 5 writes at A=0..4 with CEN=WEN=0; done on the next cycle; rows=5.
REQ-042 Continuous wr_valid for 20 rows with no wr_last -> 16 rows accepted; wr_ready=0 after the 16th; done pulse; rows=16.
REQ-043 Drain after REQ-041 with rd_ready=1 -> rd_valid over 5 consecutive cycles; data matches rows 0..4; rd_last on row 4; done pulse.
REQ-044 Drain with random rd_ready stalls -> rd_data stable while stalled; no extra CEN=0 cycles; all 5 rows delivered in order.
REQ-045 drain_start when rows=0 -> done pulse next cycle; CEN stays all ones; rd_valid never asserted.
REQ-046 rst_n low during DRAIN at row 2 -> all outputs at reset values immediately; rows=0; a subsequent fill_start is accepted.
